// File: rtl/dmem_lsu.sv
`default_nettype none
// ============================================================================
// Module   : dmem_lsu
// Brief    : RV32I load/store unit between the core data port and a
//            synchronous-read byte-enabled SRAM. One request outstanding;
//            lane-aligned stores, sign/zero-extended loads, error response
//            for misaligned accesses or illegal funct3.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_lsu #(
    parameter int ADDR_W  = 10,
    parameter int MEM_LAT = 1
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              busy,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;
    localparam logic [2:0] C_LAT   = 3'(MEM_LAT);

    logic [1:0]        state_q, state_d;
    logic              we_q, we_d;
    logic [2:0]        f3_q, f3_d;
    logic [1:0]        off_q, off_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              mem_en_q, mem_en_d;
    logic [3:0]        mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;

    logic              w_bad;
    logic [3:0]        w_we;
    logic [31:0]       w_wdata;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [31:0]       w_load;

    // Address bits above the SRAM word index wrap silently.
    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr[31:ADDR_W+2];

    // Decode the incoming request: legality, lane enables and replicated data.
    always_comb begin
        w_bad   = 1'b0;
        w_we    = 4'b0000;
        w_wdata = req_wdata;
        if (req_we) begin
            w_bad = req_funct3[2] || (req_funct3[1:0] == 2'd3);
        end else begin
            w_bad = (req_funct3[1:0] == 2'd3) || (req_funct3 == 3'b110);
        end
        if ((req_funct3[1:0] == 2'd1) && req_addr[0]) begin
            w_bad = 1'b1;
        end
        if ((req_funct3[1:0] == 2'd2) && (req_addr[1:0] != 2'b00)) begin
            w_bad = 1'b1;
        end
        if (req_we) begin
            case (req_funct3[1:0])
                2'd0: begin
                    w_we    = 4'b0001 << req_addr[1:0];
                    w_wdata = {4{req_wdata[7:0]}};
                end
                2'd1: begin
                    w_we    = req_addr[1] ? 4'b1100 : 4'b0011;
                    w_wdata = {2{req_wdata[15:0]}};
                end
                default: w_we = 4'b1111;
            endcase
        end
    end

    // Pick the addressed lane out of the returned word and extend it.
    always_comb begin
        case (off_q)
            2'd0:    w_byte = mem_rdata[7:0];
            2'd1:    w_byte = mem_rdata[15:8];
            2'd2:    w_byte = mem_rdata[23:16];
            default: w_byte = mem_rdata[31:24];
        endcase
        w_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (f3_q)
            3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b010:  w_load = mem_rdata;
            3'b100:  w_load = {24'd0, w_byte};
            3'b101:  w_load = {16'd0, w_half};
            default: w_load = 32'd0;
        endcase
    end

    // State register and all datapath flops; reset aborts any request.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q     <= S_IDLE;
            we_q        <= 1'b0;
            f3_q        <= 3'd0;
            off_q       <= 2'd0;
            cnt_q       <= 3'd0;
            rdata_q     <= 32'd0;
            err_q       <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 4'd0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            f3_q        <= f3_d;
            off_q       <= off_d;
            cnt_q       <= cnt_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Next-state sequencing.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (req_valid) state_d = w_bad ? S_RESP : S_ISSUE;
            S_ISSUE: state_d = we_q ? S_RESP : S_WAIT;
            S_WAIT:  if (cnt_q == 3'd1) state_d = S_RESP;
            default: if (rsp_ready) state_d = S_IDLE;
        endcase
    end

    // Next values of the registered SRAM strobes and response fields.
    always_comb begin
        we_d        = we_q;
        f3_d        = f3_q;
        off_d       = off_q;
        cnt_d       = cnt_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 4'b0000;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    f3_d    = req_funct3;
                    off_d   = req_addr[1:0];
                    rdata_d = 32'd0;
                    err_d   = w_bad;
                    if (!w_bad) begin
                        mem_en_d    = 1'b1;
                        mem_we_d    = w_we;
                        mem_addr_d  = req_addr[ADDR_W+1:2];
                        mem_wdata_d = w_wdata;
                    end
                end
            end
            S_ISSUE: begin
                if (!we_q) cnt_d = C_LAT;
            end
            S_WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) rdata_d = w_load;
            end
            default: begin
                if (rsp_ready) begin
                    rdata_d = 32'd0;
                    err_d   = 1'b0;
                end
            end
        endcase
    end

    assign req_ready = (state_q == S_IDLE) && RSTn;
    assign busy      = (state_q != S_IDLE);
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_lsu
// Brief    : Self-checking bench for dmem_lsu. Two instances (read latency 1
//            and 3) share one SRAM model; a behavioural byte-array model
//            predicts every response and SRAM strobe.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_lsu;

    logic        CLK = 1'b0;
    logic        RSTn;
    logic        sel;
    logic        req_valid, req_we, rsp_ready;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic [31:0] mem_rdata;

    logic        a_req_ready [2], a_rsp_valid [2], a_rsp_err [2], a_busy [2], a_mem_en [2];
    logic [31:0] a_rsp_rdata [2], a_mem_wdata [2];
    logic [3:0]  a_mem_we [2];
    logic [9:0]  a_mem_addr [2];
    logic        rv0, rv1;

    logic        req_ready, rsp_valid, rsp_err, busy, mem_en;
    logic [31:0] rsp_rdata, mem_wdata;
    logic [3:0]  mem_we;
    logic [9:0]  mem_addr;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;
    int en_cnt  = 0;
    int en_cyc  = 0;
    int viol    = 0;
    logic [3:0]  en_we;
    logic [9:0]  en_addr;
    logic [31:0] en_wd;
    logic [31:0] last_rd;

    logic [31:0] sram    [1024];
    logic [31:0] ref_mem [1024];
    logic [31:0] rpipe   [4];
    logic        mem_init = 1'b0;

    always #5 CLK = ~CLK;

    assign rv0 = req_valid & ~sel;
    assign rv1 = req_valid & sel;

    dmem_lsu #(.ADDR_W(10), .MEM_LAT(1)) u_dut1 (
        .CLK(CLK), .RSTn(RSTn), .req_valid(rv0), .req_ready(a_req_ready[0]),
        .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(a_rsp_valid[0]), .rsp_ready(rsp_ready), .rsp_rdata(a_rsp_rdata[0]),
        .rsp_err(a_rsp_err[0]), .busy(a_busy[0]), .mem_en(a_mem_en[0]), .mem_we(a_mem_we[0]),
        .mem_addr(a_mem_addr[0]), .mem_wdata(a_mem_wdata[0]), .mem_rdata(mem_rdata)
    );

    dmem_lsu #(.ADDR_W(10), .MEM_LAT(3)) u_dut3 (
        .CLK(CLK), .RSTn(RSTn), .req_valid(rv1), .req_ready(a_req_ready[1]),
        .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(a_rsp_valid[1]), .rsp_ready(rsp_ready), .rsp_rdata(a_rsp_rdata[1]),
        .rsp_err(a_rsp_err[1]), .busy(a_busy[1]), .mem_en(a_mem_en[1]), .mem_we(a_mem_we[1]),
        .mem_addr(a_mem_addr[1]), .mem_wdata(a_mem_wdata[1]), .mem_rdata(mem_rdata)
    );

    always_comb begin
        req_ready = a_req_ready[sel];
        rsp_valid = a_rsp_valid[sel];
        rsp_err   = a_rsp_err[sel];
        rsp_rdata = a_rsp_rdata[sel];
        busy      = a_busy[sel];
        mem_en    = a_mem_en[sel];
        mem_we    = a_mem_we[sel];
        mem_addr  = a_mem_addr[sel];
        mem_wdata = a_mem_wdata[sel];
    end

    function automatic logic [31:0] pat(input int i);
        return (i == 8) ? 32'h80FF7F01 : (32'(i) * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    // SRAM model: byte-enabled writes, reads visible after the selected latency;
    // off-cycle read data is random so a mistimed capture shows up.
    always @(posedge CLK) begin
        if (!mem_init) begin
            for (int i = 0; i < 1024; i++) sram[i] = pat(i);
            mem_init = 1'b1;
        end
        rpipe[0] <= $urandom;
        if (mem_en) begin
            if (mem_we == 4'b0000) rpipe[0] <= sram[mem_addr];
            for (int i = 0; i < 4; i++)
                if (mem_we[i]) sram[mem_addr][8*i +: 8] = mem_wdata[8*i +: 8];
        end
        for (int i = 1; i < 4; i++) rpipe[i] <= rpipe[i-1];
        cyc <= cyc + 1;
    end
    assign mem_rdata = rpipe[sel ? 2 : 0];

    // Record each SRAM strobe and flag write enables seen without mem_en.
    always @(negedge CLK) begin
        if (mem_en) begin
            en_cnt  <= en_cnt + 1;
            en_cyc  <= cyc;
            en_we   <= mem_we;
            en_addr <= mem_addr;
            en_wd   <= mem_wdata;
        end else if (mem_we != 4'b0000) begin
            viol <= viol + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Behavioural model: accesses as byte counts over a byte-lane memory.
    function automatic void ref_model(input logic we, input logic [2:0] f3,
                                      input logic [31:0] addr, input logic [31:0] wdata,
                                      output logic err, output logic [31:0] rd,
                                      output logic [3:0] mwe, output logic [31:0] mwd);
        int n, off, idx;
        longint v;
        n = 0;
        if (we) begin
            case (f3)
                3'd0: n = 1;
                3'd1: n = 2;
                3'd2: n = 4;
                default: n = 0;
            endcase
        end else begin
            case (f3)
                3'd0, 3'd4: n = 1;
                3'd1, 3'd5: n = 2;
                3'd2:       n = 4;
                default:    n = 0;
            endcase
        end
        off = int'(addr % 4);
        idx = int'((addr / 4) % 1024);
        err = (n == 0) ? 1'b1 : ((addr % n) != 0);
        rd = 0; mwe = 0; mwd = 0;
        if (!err && we) begin
            for (int i = 0; i < 4; i++) mwd[8*i +: 8] = wdata[8*(i % n) +: 8];
            for (int i = 0; i < n; i++) begin
                mwe[off+i] = 1'b1;
                ref_mem[idx][8*(off+i) +: 8] = wdata[8*i +: 8];
            end
        end else if (!err) begin
            v = longint'(ref_mem[idx] >> (8 * off)) % (64'sd1 << (8 * n));
            if (f3 < 3'd4 && n < 4 && v >= (64'sd1 << (8 * n - 1))) v = v - (64'sd1 << (8 * n));
            rd = v[31:0];
        end
    endfunction

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input int stall_in);
        logic e_err, seen, done, hold_err;
        logic [31:0] e_rd, e_wd, hold_rd;
        logic [3:0] e_we;
        int e_lat, t0, en0, guard, stall;
        stall = stall_in;
        ref_model(we, f3, addr, wdata, e_err, e_rd, e_we, e_wd);
        e_lat = e_err ? 1 : (we ? 2 : 2 + (sel ? 3 : 1));
        @(negedge CLK);
        check("req_ready_idle", {31'd0, req_ready}, 1);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        rsp_ready = 1'b0;
        en0 = en_cnt;
        @(negedge CLK);
        t0 = cyc;
        seen = 1'b0; done = 1'b0; guard = 0; hold_rd = 0; hold_err = 0;
        while (!done && guard < 40) begin
            if (seen) begin
                check("hold_valid", {31'd0, rsp_valid}, 1);
                check("hold_rdata", rsp_rdata, hold_rd);
                check("hold_err", {31'd0, rsp_err}, {31'd0, hold_err});
                check("hold_ready", {31'd0, req_ready}, 0);
                check("hold_busy", {31'd0, busy}, 1);
            end else if (rsp_valid) begin
                seen = 1'b1;
                check("latency", cyc - t0 + 1, e_lat);
                check("rsp_rdata", rsp_rdata, e_rd);
                check("rsp_err", {31'd0, rsp_err}, {31'd0, e_err});
                hold_rd = rsp_rdata; hold_err = rsp_err; last_rd = rsp_rdata;
            end
            if (seen && stall == 0) begin
                rsp_ready = 1'b1;
                done = 1'b1;
            end else begin
                if (seen) stall--;
                req_valid  = 1'($urandom_range(0, 1));
                req_we     = 1'($urandom_range(0, 1));
                req_funct3 = 3'($urandom_range(0, 7));
                req_addr   = $urandom;
                req_wdata  = $urandom;
                @(negedge CLK);
                guard++;
            end
        end
        check("rsp_seen", {31'd0, seen}, 1);
        @(negedge CLK);
        req_valid = 1'b0; rsp_ready = 1'b0;
        check("rsp_drop", {31'd0, rsp_valid}, 0);
        check("ready_back", {31'd0, req_ready}, 1);
        if (e_err) begin
            check("no_mem_en", en_cnt - en0, 0);
        end else begin
            check("mem_en_pulses", en_cnt - en0, 1);
            check("mem_en_cycle", en_cyc, t0);
            check("mem_addr", {22'd0, en_addr}, {22'd0, addr[11:2]});
            check("mem_we", {28'd0, en_we}, {28'd0, e_we});
            if (we) check("mem_wdata", en_wd, e_wd);
        end
    endtask

    initial begin
        logic [31:0] a;
        for (int i = 0; i < 1024; i++) ref_mem[i] = pat(i);
        RSTn = 1'b0; sel = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'd0; req_wdata = 32'd0; rsp_ready = 1'b0; last_rd = 32'd0;
        repeat (3) @(negedge CLK);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 0);
        check("rst_mem_en", {31'd0, mem_en}, 0);
        check("rst_mem_we", {28'd0, mem_we}, 0);
        check("rst_mem_addr", {22'd0, mem_addr}, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_rsp_err", {31'd0, rsp_err}, 0);
        RSTn = 1'b1;
        @(negedge CLK);
        check("rst_req_ready", {31'd0, req_ready}, 1);

        // Latency-1 instance: loads, stores, errors, back-pressure.
        do_req(1'b0, 3'b000, 32'h23, 32'h0, 0); check("lb_23", last_rd, 32'hFFFFFF80);
        do_req(1'b0, 3'b100, 32'h21, 32'h0, 0); check("lbu_21", last_rd, 32'h0000007F);
        do_req(1'b0, 3'b001, 32'h22, 32'h0, 0); check("lh_22", last_rd, 32'hFFFF80FF);
        do_req(1'b0, 3'b101, 32'h22, 32'h0, 0); check("lhu_22", last_rd, 32'h000080FF);
        do_req(1'b0, 3'b010, 32'h20, 32'h0, 0); check("lw_20", last_rd, 32'h80FF7F01);
        do_req(1'b1, 3'b000, 32'h45, 32'h123456AB, 0);
        check("sb_addr", {22'd0, en_addr}, 32'h11);
        check("sb_we", {28'd0, en_we}, 32'h2);
        check("sb_wdata", en_wd, 32'hABABABAB);
        do_req(1'b1, 3'b001, 32'h46, 32'h0000BEEF, 0);
        check("sh_we", {28'd0, en_we}, 32'hC);
        check("sh_wdata", en_wd, 32'hBEEFBEEF);
        do_req(1'b0, 3'b010, 32'h06, 32'h0, 0);
        do_req(1'b1, 3'b001, 32'h03, 32'hFFFF, 0);
        do_req(1'b0, 3'b011, 32'h20, 32'h0, 0);
        do_req(1'b0, 3'b010, 32'h20, 32'h0, 5);

        // Latency-3 instance.
        sel = 1'b1;
        do_req(1'b0, 3'b010, 32'h20, 32'h0, 0); check("lw_lat3", last_rd, 32'h80FF7F01);

        // Reset while waiting on the SRAM.
        @(negedge CLK);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h20;
        @(negedge CLK);
        req_valid = 1'b0;
        @(negedge CLK);
        check("mid_busy_pre", {31'd0, busy}, 1);
        RSTn = 1'b0;
        #1;
        check("mid_busy", {31'd0, busy}, 0);
        check("mid_rsp_valid", {31'd0, rsp_valid}, 0);
        check("mid_mem_en", {31'd0, mem_en}, 0);
        check("mid_mem_we", {28'd0, mem_we}, 0);
        check("mid_mem_addr", {22'd0, mem_addr}, 0);
        check("mid_mem_wdata", mem_wdata, 0);
        check("mid_rsp_rdata", rsp_rdata, 0);
        check("mid_rsp_err", {31'd0, rsp_err}, 0);
        @(negedge CLK);
        RSTn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            check("no_stale_rsp", {31'd0, rsp_valid}, 0);
        end
        do_req(1'b0, 3'b010, 32'h20, 32'h0, 0); check("lw_after_rst", last_rd, 32'h80FF7F01);

        // Randomized traffic over both instances.
        for (int k = 0; k < 400; k++) begin
            sel = 1'($urandom_range(0, 1));
            a = $urandom;
            a[11:8] = 4'd0;
            do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom,
                   ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
        end

        check("we_without_en", viol, 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
Load/store unit between the CPU core's data-memory port and a synchronous-read data SRAM with byte enables. Accepts one RV32I load/store request at a time over a valid/ready handshake. Decodes funct3 into byte/half/word accesses and drives lane-aligned byte enables and write data. Waits the SRAM's fixed read latency, then returns a sign- or zero-extended load result, or an error for misaligned or illegal accesses.

Parameters:
ADDR_W, 10, SRAM word-address width (words = 2^ADDR_W)
MEM_LAT, 1, SRAM read latency in cycles, legal range 1..4

Ports:
CLK  in  1  clock
RSTn  in  1  asynchronous active-low reset
req_valid  in  1  core presents a request
req_ready  out  1  LSU can accept a request
req_we  in  1  1=store, 0=load
req_funct3  in  3  RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
req_addr  in  32  byte address (ALU result)
req_wdata  in  32  store data (rs2)
rsp_valid  out  1  response available
rsp_ready  in  1  core consumes response
rsp_rdata  out  32  extended load data; 0 for stores/errors
rsp_err  out  1  misaligned or illegal funct3
busy  out  1  state != IDLE (core stall)
mem_en  out  1  SRAM access strobe, one cycle per access
mem_we  out  4  byte write enables, lane i = bits [8i+7:8i]
mem_addr  out  ADDR_W  word address
mem_wdata  out  32  lane-replicated store data
mem_rdata  in  32  read data, valid exactly MEM_LAT cycles after mem_en with mem_we=0

Behaviour:
- Reset: RSTn is asynchronous, active-low; clock is CLK.
- Reset values: state=IDLE; req_ready=1 once RSTn is high. rsp_valid, rsp_err, busy, mem_en=0; mem_we=0; mem_addr, mem_wdata, rsp_rdata=0.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: req_ready=1. On req_valid at edge T, register we, funct3, addr, wdata. Go to ISSUE, or to RESP with err=1 if the request is invalid.
- Invalid requests:
  - Load funct3 ∈ {011,110,111}.
  - Store funct3 ∉ {000,001,010}.
  - Half access with addr[0]=1.
  - Word access with addr[1:0]≠00.
  - Invalid requests never assert mem_en. rsp_valid rises at T+1 with rsp_rdata=0.
- ISSUE (one cycle, registered outputs):
  - mem_en=1; mem_addr=addr[ADDR_W+1:2]. Upper address bits are ignored (wrap, no error).
  - Store byte: mem_we=1<<addr[1:0]; mem_wdata={4{wdata[7:0]}}.
  - Store half: mem_we = 0011 or 1100 by addr[1]; mem_wdata={2{wdata[15:0]}}.
  - Store word: mem_we=1111; mem_wdata=wdata.
  - Load: mem_we=0000.
  - Store → RESP. Load → WAIT with a 3-bit counter loaded to MEM_LAT.
- WAIT: decrement the counter each cycle. When it reaches the sample point (MEM_LAT cycles after the ISSUE cycle), capture mem_rdata, extract and extend, then go to RESP.
  - Extraction: byte = lane addr[1:0]; half = bits [31:16] if addr[1] else [15:0].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- RESP: rsp_valid=1. rsp_rdata and rsp_err are held stable while rsp_ready=0. When rsp_ready=1 at the edge, go to IDLE; req_ready is high the following cycle. rsp_valid never asserts outside RESP.
- Latency from accept edge T to first rsp_valid cycle:
  - Error: T+1.
  - Store: T+2.
  - Load: T+2+MEM_LAT.
- One outstanding request only. req_* is ignored outside IDLE.
- mem_en is a single-cycle pulse. mem_we is 0 whenever mem_en=0.
- Reset mid-operation: all state and outputs return immediately to reset values. Any in-flight mem_rdata is discarded, and no response is produced for the aborted request.

Test Plan:
- Preload word 8 = 0x80FF7F01. LB @0x23 → mem_addr=8, mem_we=0000; rsp_rdata=0xFFFFFF80 at T+3 (MEM_LAT=1); LBU @0x21 → 0x0000007F.
- Same word: LH @0x22 → 0xFFFF80FF; LHU @0x22 → 0x000080FF; LW @0x20 → 0x80FF7F01; rerun with MEM_LAT=3 → rsp_valid at T+5.
- SB @0x45 data 0x123456AB → mem_addr=0x11, mem_we=0010, mem_wdata=0xABABABAB; SH @0x46 data 0x0000BEEF → mem_we=1100, mem_wdata=0xBEEFBEEF; rsp_valid at T+2, rsp_rdata=0.
- LW @0x06, SH @0x03, load funct3=011 → rsp_err=1 at T+1, mem_en never asserted, rsp_rdata=0.
- LW with rsp_ready=0 for 5 cycles → rsp_valid and rsp_rdata stable, req_ready=0, busy=1; a new req_valid in that window is not accepted.
- Assert RSTn=0 during WAIT → outputs return to reset values at once; after release, LW @0x20 completes normally with 0x80FF7F01 and no stale response.
